// File: rtl/mgmt_wb_pkg.sv
// Shared types and constants for the management Wishbone bridge.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package mgmt_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    localparam logic [31:0] TIMEOUT_DATA_DEF = 32'hDEAD_BEEF;

    // Width of a channel index; a single channel still needs one bit
    function automatic int ch_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mgmt_wb_addr_decode.sv
// Priority address decoder: hit flag, one-hot select and index of the matching channel.
// Latency: combinational.
// Backpressure: none; it is a pure function of the address.
module mgmt_wb_addr_decode
    import mgmt_wb_pkg::*;
#(
    parameter int                     NUM_CH  = 2,
    parameter int                     AW      = 32,
    parameter logic [NUM_CH*AW-1:0]   CH_BASE = '0,
    parameter logic [NUM_CH*AW-1:0]   CH_MASK = '0,
    parameter int                     IW      = ch_idx_w(NUM_CH)
) (
    input  logic [AW-1:0]     adr_i,
    output logic              hit_o,
    output logic [NUM_CH-1:0] onehot_o,
    output logic [IW-1:0]     idx_o
);

    // Scan from the top down so the lowest matching channel is the last one written
    always_comb begin
        hit_o    = 1'b0;
        onehot_o = '0;
        idx_o    = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if ((adr_i & CH_MASK[i*AW +: AW]) == CH_BASE[i*AW +: AW]) begin
                hit_o    = 1'b1;
                onehot_o = NUM_CH'(1) << i;
                idx_o    = IW'(i);
            end
        end
    end

endmodule

// File: rtl/mgmt_wb_user_bridge.sv
// Routes the management Wishbone master to NUM_CH exported slave ports with timeout/error handling.
// Latency: stb sampled at edge N -> s_stb_o after N; slave ack sampled at edge K -> m_ack_o after K.
// Backpressure: one transaction in flight; new requests are sampled only in IDLE.
module mgmt_wb_user_bridge
    import mgmt_wb_pkg::*;
#(
    parameter int                   NUM_CH       = 2,
    parameter int                   AW           = 32,
    parameter logic [NUM_CH*AW-1:0] CH_BASE      = {32'h3000_0000, 32'h2600_0000},
    parameter logic [NUM_CH*AW-1:0] CH_MASK      = {32'hF000_0000, 32'hFF00_0000},
    parameter int                   TIMEOUT      = 255,
    parameter logic [31:0]          TIMEOUT_DATA = TIMEOUT_DATA_DEF
) (
    input  logic                 core_clk,
    input  logic                 core_rst,
    input  logic                 m_cyc_i,
    input  logic                 m_stb_i,
    input  logic                 m_we_i,
    input  logic [3:0]           m_sel_i,
    input  logic [AW-1:0]        m_adr_i,
    input  logic [31:0]          m_dat_i,
    output logic                 m_ack_o,
    output logic                 m_err_o,
    output logic [31:0]          m_dat_o,
    output logic [NUM_CH-1:0]    s_cyc_o,
    output logic [NUM_CH-1:0]    s_stb_o,
    output logic                 s_we_o,
    output logic [3:0]           s_sel_o,
    output logic [AW-1:0]        s_adr_o,
    output logic [31:0]          s_dat_o,
    output logic [NUM_CH-1:0]    s_iena_o,
    input  logic [NUM_CH-1:0]    s_ack_i,
    input  logic [NUM_CH*32-1:0] s_dat_i,
    input  logic                 clr_timeout_i,
    output logic                 timeout_flag_o,
    output logic [2:0]           timeout_ch_o
);

    localparam int IW = ch_idx_w(NUM_CH);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       ch_q, ch_d;
    logic [NUM_CH-1:0]   cyc_q, cyc_d, stb_q, stb_d, iena_q, iena_d;
    logic                we_q, we_d, ack_q, ack_d, err_q, err_d;
    logic [3:0]          sel_q, sel_d;
    logic [AW-1:0]       adr_q, adr_d;
    logic [31:0]         wdat_q, wdat_d, mdat_q, mdat_d;
    logic                tflag_q, tflag_d;
    logic [2:0]          tch_q, tch_d;

    logic                dec_hit;
    logic [NUM_CH-1:0]   dec_onehot;
    logic [IW-1:0]       dec_idx;
    logic                sel_ack;
    logic [31:0]         sel_rdat;

    mgmt_wb_addr_decode #(
        .NUM_CH  (NUM_CH),
        .AW      (AW),
        .CH_BASE (CH_BASE),
        .CH_MASK (CH_MASK),
        .IW      (IW)
    ) u_dec (
        .adr_i    (m_adr_i),
        .hit_o    (dec_hit),
        .onehot_o (dec_onehot),
        .idx_o    (dec_idx)
    );

    // cyc_q is one-hot on the active channel, so it masks acks and selects read data
    always_comb begin
        sel_ack  = |(s_ack_i & cyc_q);
        sel_rdat = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cyc_q[i]) begin
                sel_rdat = s_dat_i[i*32 +: 32];
            end
        end
    end

    // Next-state, datapath and status logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ch_d    = ch_q;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        iena_d  = iena_q;
        we_d    = we_q;
        sel_d   = sel_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        mdat_d  = mdat_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        tflag_d = tflag_q;
        tch_d   = tch_q;

        // A timeout raised below in the same cycle overrides this clear
        if (clr_timeout_i) begin
            tflag_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (m_cyc_i && m_stb_i) begin
                    if (dec_hit) begin
                        adr_d   = m_adr_i;
                        wdat_d  = m_dat_i;
                        we_d    = m_we_i;
                        sel_d   = m_sel_i;
                        cyc_d   = dec_onehot;
                        stb_d   = dec_onehot;
                        iena_d  = dec_onehot;
                        ch_d    = dec_idx;
                        cnt_d   = CW'(TIMEOUT);
                        state_d = ST_BUSY;
                    end else begin
                        if (!m_we_i) begin
                            mdat_d = TIMEOUT_DATA;
                        end
                        err_d   = 1'b1;
                        state_d = ST_ERR;
                    end
                end
            end
            ST_BUSY: begin
                if (!m_cyc_i) begin
                    cyc_d   = '0;
                    stb_d   = '0;
                    iena_d  = '0;
                    state_d = ST_IDLE;
                end else if (sel_ack) begin
                    mdat_d  = sel_rdat;
                    cyc_d   = '0;
                    stb_d   = '0;
                    ack_d   = 1'b1;
                    state_d = ST_RESP;
                end else if ((TIMEOUT > 0) && (cnt_q == CW'(1))) begin
                    cnt_d   = '0;
                    cyc_d   = '0;
                    stb_d   = '0;
                    mdat_d  = TIMEOUT_DATA;
                    tflag_d = 1'b1;
                    tch_d   = 3'(ch_q);
                    err_d   = 1'b1;
                    state_d = ST_ERR;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_RESP, ST_ERR: begin
                iena_d  = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops every output at once
    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ch_q    <= '0;
            cyc_q   <= '0;
            stb_q   <= '0;
            iena_q  <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            wdat_q  <= '0;
            mdat_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            tflag_q <= 1'b0;
            tch_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            iena_q  <= iena_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            mdat_q  <= mdat_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            tflag_q <= tflag_d;
            tch_q   <= tch_d;
        end
    end

    assign m_ack_o        = ack_q;
    assign m_err_o        = err_q;
    assign m_dat_o        = mdat_q;
    assign s_cyc_o        = cyc_q;
    assign s_stb_o        = stb_q;
    assign s_iena_o       = iena_q;
    assign s_we_o         = we_q;
    assign s_sel_o        = sel_q;
    assign s_adr_o        = adr_q;
    assign s_dat_o        = wdat_q;
    assign timeout_flag_o = tflag_q;
    assign timeout_ch_o   = tch_q;

endmodule

// File: tb/tb_mgmt_wb_user_bridge.sv
// Directed bench for the management Wishbone bridge (TIMEOUT shortened to 4).
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: slave acks driven by hand per step.
module tb_mgmt_wb_user_bridge;

    logic        core_clk = 1'b0;
    logic        core_rst;
    logic        m_cyc_i, m_stb_i, m_we_i;
    logic [3:0]  m_sel_i;
    logic [31:0] m_adr_i, m_dat_i;
    logic        m_ack_o, m_err_o;
    logic [31:0] m_dat_o;
    logic [1:0]  s_cyc_o, s_stb_o, s_iena_o, s_ack_i;
    logic        s_we_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic [63:0] s_dat_i;
    logic        clr_timeout_i, timeout_flag_o;
    logic [2:0]  timeout_ch_o;

    int tests = 0;
    int fails = 0;

    always #5 core_clk = ~core_clk;

    mgmt_wb_user_bridge #(.TIMEOUT(4)) dut (
        .core_clk       (core_clk),
        .core_rst       (core_rst),
        .m_cyc_i        (m_cyc_i),
        .m_stb_i        (m_stb_i),
        .m_we_i         (m_we_i),
        .m_sel_i        (m_sel_i),
        .m_adr_i        (m_adr_i),
        .m_dat_i        (m_dat_i),
        .m_ack_o        (m_ack_o),
        .m_err_o        (m_err_o),
        .m_dat_o        (m_dat_o),
        .s_cyc_o        (s_cyc_o),
        .s_stb_o        (s_stb_o),
        .s_we_o         (s_we_o),
        .s_sel_o        (s_sel_o),
        .s_adr_o        (s_adr_o),
        .s_dat_o        (s_dat_o),
        .s_iena_o       (s_iena_o),
        .s_ack_i        (s_ack_i),
        .s_dat_i        (s_dat_i),
        .clr_timeout_i  (clr_timeout_i),
        .timeout_flag_o (timeout_flag_o),
        .timeout_ch_o   (timeout_ch_o)
    );

    task automatic step();
        @(posedge core_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic we, input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
        m_cyc_i = 1'b1;
        m_stb_i = 1'b1;
        m_we_i  = we;
        m_adr_i = adr;
        m_sel_i = sel;
        m_dat_i = dat;
    endtask

    task automatic idle_master();
        m_cyc_i = 1'b0;
        m_stb_i = 1'b0;
        m_we_i  = 1'b0;
    endtask

    initial begin
        core_rst = 1'b1;
        idle_master();
        m_sel_i = '0; m_adr_i = '0; m_dat_i = '0;
        s_ack_i = '0; s_dat_i = '0; clr_timeout_i = 1'b0;
        step(); step();

        // Reset state
        chk("rst_ack",  {63'd0, m_ack_o}, 64'd0);
        chk("rst_err",  {63'd0, m_err_o}, 64'd0);
        chk("rst_mdat", {32'd0, m_dat_o}, 64'd0);
        chk("rst_cyc",  {62'd0, s_cyc_o}, 64'd0);
        chk("rst_stb",  {62'd0, s_stb_o}, 64'd0);
        chk("rst_iena", {62'd0, s_iena_o}, 64'd0);
        chk("rst_flag", {63'd0, timeout_flag_o}, 64'd0);
        chk("rst_tch",  {61'd0, timeout_ch_o}, 64'd0);
        core_rst = 1'b0;
        step();

        // 1: read ch0, ack one cycle after stb
        req(1'b0, 32'h2600_0010, 4'hF, 32'h0);
        step();
        chk("t1_stb",  {62'd0, s_stb_o}, 64'h1);
        chk("t1_iena", {62'd0, s_iena_o}, 64'h1);
        chk("t1_adr",  {32'd0, s_adr_o}, 64'h2600_0010);
        chk("t1_ack0", {63'd0, m_ack_o}, 64'd0);
        s_ack_i = 2'b01; s_dat_i[31:0] = 32'h1234_5678;
        step();
        s_ack_i = 2'b00;
        chk("t1_ack",   {63'd0, m_ack_o}, 64'd1);
        chk("t1_mdat",  {32'd0, m_dat_o}, 64'h1234_5678);
        chk("t1_stbd",  {62'd0, s_stb_o}, 64'd0);
        chk("t1_ienar", {62'd0, s_iena_o}, 64'h1);
        idle_master();
        step();
        chk("t1_ackp",  {63'd0, m_ack_o}, 64'd0);
        chk("t1_ienai", {62'd0, s_iena_o}, 64'd0);

        // 2: write ch1, spurious ch0 ack ignored
        req(1'b1, 32'h3000_0004, 4'b0011, 32'hA5A5_0001);
        step();
        chk("t2_stb",  {62'd0, s_stb_o}, 64'h2);
        chk("t2_sel",  {60'd0, s_sel_o}, 64'h3);
        chk("t2_we",   {63'd0, s_we_o}, 64'd1);
        chk("t2_wdat", {32'd0, s_dat_o}, 64'hA5A5_0001);
        chk("t2_iena", {62'd0, s_iena_o}, 64'h2);
        s_ack_i = 2'b01;
        step();
        chk("t2_ign_ack", {63'd0, m_ack_o}, 64'd0);
        chk("t2_ign_stb", {62'd0, s_stb_o}, 64'h2);
        s_ack_i = 2'b10; s_dat_i[63:32] = 32'hCAFE_0002;
        step();
        s_ack_i = 2'b00;
        chk("t2_ack",  {63'd0, m_ack_o}, 64'd1);
        chk("t2_mdat", {32'd0, m_dat_o}, 64'hCAFE_0002);
        idle_master();
        step();
        chk("t2_ackp", {63'd0, m_ack_o}, 64'd0);

        // 3: decode miss
        req(1'b0, 32'h1000_0000, 4'hF, 32'h0);
        step();
        chk("t3_stb",  {62'd0, s_stb_o}, 64'd0);
        chk("t3_err",  {63'd0, m_err_o}, 64'd1);
        chk("t3_mdat", {32'd0, m_dat_o}, 64'hDEAD_BEEF);
        idle_master();
        step();
        chk("t3_errp", {63'd0, m_err_o}, 64'd0);

        // 4: ch1 never acks -> timeout after 4 BUSY cycles
        s_dat_i = '0;
        req(1'b0, 32'h3000_0000, 4'hF, 32'h0);
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_noerr", {63'd0, m_err_o}, 64'd0);
            chk("t4_stb",   {62'd0, s_stb_o}, 64'h2);
        end
        step();
        chk("t4_err",  {63'd0, m_err_o}, 64'd1);
        chk("t4_flag", {63'd0, timeout_flag_o}, 64'd1);
        chk("t4_tch",  {61'd0, timeout_ch_o}, 64'd1);
        chk("t4_mdat", {32'd0, m_dat_o}, 64'hDEAD_BEEF);
        chk("t4_stbd", {62'd0, s_stb_o}, 64'd0);
        chk("t4_iena", {62'd0, s_iena_o}, 64'h2);
        idle_master();
        step();
        chk("t4_errp",   {63'd0, m_err_o}, 64'd0);
        chk("t4_sticky", {63'd0, timeout_flag_o}, 64'd1);
        clr_timeout_i = 1'b1;
        step();
        clr_timeout_i = 1'b0;
        chk("t4_clr", {63'd0, timeout_flag_o}, 64'd0);

        // 5: abort during BUSY, then a normal write
        req(1'b0, 32'h2600_0000, 4'hF, 32'h0);
        step();
        chk("t5_cyc", {62'd0, s_cyc_o}, 64'h1);
        idle_master();
        step();
        chk("t5_cycd", {62'd0, s_cyc_o}, 64'd0);
        chk("t5_iena", {62'd0, s_iena_o}, 64'd0);
        chk("t5_ack",  {63'd0, m_ack_o}, 64'd0);
        chk("t5_err",  {63'd0, m_err_o}, 64'd0);
        chk("t5_mdat", {32'd0, m_dat_o}, 64'hDEAD_BEEF);
        step();
        chk("t5_ack2", {63'd0, m_ack_o | m_err_o}, 64'd0);
        req(1'b1, 32'h2600_0020, 4'hF, 32'h0000_5555);
        step();
        chk("t5_stb", {62'd0, s_stb_o}, 64'h1);
        s_ack_i = 2'b01;
        step();
        s_ack_i = 2'b00;
        chk("t5_ackn", {63'd0, m_ack_o}, 64'd1);
        idle_master();
        step();

        // 6: reset mid-BUSY, then back-to-back reads ch0, ch1
        req(1'b0, 32'h3000_0008, 4'hF, 32'h0);
        step();
        chk("t6_busy", {62'd0, s_cyc_o}, 64'h2);
        core_rst = 1'b1;
        #1;
        chk("t6_cyc",  {62'd0, s_cyc_o}, 64'd0);
        chk("t6_stb",  {62'd0, s_stb_o}, 64'd0);
        chk("t6_iena", {62'd0, s_iena_o}, 64'd0);
        chk("t6_mdat", {32'd0, m_dat_o}, 64'd0);
        chk("t6_adr",  {32'd0, s_adr_o}, 64'd0);
        idle_master();
        step();
        core_rst = 1'b0;
        step();
        req(1'b0, 32'h2600_0100, 4'hF, 32'h0);
        step();
        chk("t6_stb0", {62'd0, s_stb_o}, 64'h1);
        s_ack_i = 2'b01; s_dat_i[31:0] = 32'h0BAD_F00D;
        step();
        s_ack_i = 2'b00;
        chk("t6_ack0", {63'd0, m_ack_o}, 64'd1);
        chk("t6_dat0", {32'd0, m_dat_o}, 64'h0BAD_F00D);
        m_adr_i = 32'h3000_0100;
        step();
        chk("t6_gap", {63'd0, m_ack_o}, 64'd0);
        step();
        chk("t6_stb1", {62'd0, s_stb_o}, 64'h2);
        s_ack_i = 2'b10; s_dat_i[63:32] = 32'h7777_1111;
        step();
        s_ack_i = 2'b00;
        chk("t6_ack1", {63'd0, m_ack_o}, 64'd1);
        chk("t6_dat1", {32'd0, m_dat_o}, 64'h7777_1111);
        idle_master();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
